// File: rtl/mem_ctrl_pkg.sv
// Shared types and default widths for the memory access front end.
//   state_t    : access sequencer states
//   ADDR_W_DEF : default memory address width
//   DATA_W_DEF : default memory data width
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser followed by a stability counter for one board switch.
//   clock  : system clock
//   resetn : synchronous active-low reset
//   raw    : asynchronous, bouncy switch input
//   level  : debounced level; follows raw only after it has been stable
//            for DEBOUNCE_CYCLES consecutive synchronised samples
module sw_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            // any sample agreeing with the accepted level restarts the window
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Front end between the board switches and a single-port synchronous RAM.
// Each debounced rising edge of the step switch produces exactly one RAM
// access; read results are held in rd_data for the 7-segment display.
//   clock, resetn      : system clock, synchronous active-low reset
//   step_sw, wr_sw     : raw step and W/R (1=write) switches
//   addr_sw, data_sw   : raw address / write-data switches
//   mem_addr, mem_data : latched access address and write data
//   mem_en, mem_wren   : one-cycle access strobe and its write qualifier
//   mem_q              : RAM read data, valid READ_LAT cycles after mem_en
//   rd_data, rd_valid  : last captured read, and whether it is newer than any write
//   busy               : access in flight
//   op_count           : completed accesses, mod 256
//
// state | meaning
// IDLE  | waiting for a step press; switches latched on press
// ISSUE | mem_en strobe for one cycle
// WAIT  | read in flight, counting down the RAM latency
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W          = ADDR_W_DEF,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int READ_LAT        = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              step_sw,
    input  logic              wr_sw,
    input  logic [ADDR_W-1:0] addr_sw,
    input  logic [DATA_W-1:0] data_sw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic [7:0]        op_count
);

    localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    logic              step_lvl;
    logic              step_lvl_d;
    logic              step_rise;
    logic              wr_lvl;
    logic              wr_q;
    logic [WAIT_W-1:0] wait_cnt;
    state_t            state;
    state_t            state_nxt;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .clock  (clock),
        .resetn (resetn),
        .raw    (step_sw),
        .level  (step_lvl)
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr_db (
        .clock  (clock),
        .resetn (resetn),
        .raw    (wr_sw),
        .level  (wr_lvl)
    );

    assign step_rise = step_lvl & ~step_lvl_d;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_wren  = 1'b0;
        unique case (state)
            IDLE: begin
                if (step_rise) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_wren  = wr_q;
                state_nxt = wr_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            step_lvl_d <= 1'b0;
            wr_q       <= 1'b0;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            op_count   <= 8'd0;
        end else begin
            step_lvl_d <= step_lvl;
            unique case (state)
                IDLE: begin
                    // presses seen in any other state are simply dropped
                    if (step_rise) begin
                        mem_addr <= addr_sw;
                        mem_data <= data_sw;
                        wr_q     <= wr_lvl;
                    end
                end
                ISSUE: begin
                    if (wr_q) begin
                        rd_valid <= 1'b0;
                        op_count <= op_count + 8'd1;
                    end else begin
                        wait_cnt <= WAIT_W'(READ_LAT - 1);
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        rd_data  <= mem_q;
                        rd_valid <= 1'b1;
                        op_count <= op_count + 8'd1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;
    localparam int DEB       = 4;
    localparam int READ_LAT  = 2;
    localparam int SLOW_LAT  = 20;

    logic              clock = 1'b0;
    logic              resetn;
    logic              step_sw;
    logic              wr_sw;
    logic [ADDR_W-1:0] addr_sw;
    logic [DATA_W-1:0] data_sw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              mem_en;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic [7:0]        op_count;

    // second instance with a long read latency so that a clean press can land mid-read
    logic              slow_step_sw;
    logic              slow_wr_sw;
    logic [ADDR_W-1:0] slow_mem_addr;
    logic [DATA_W-1:0] slow_mem_data;
    logic              slow_mem_wren;
    logic              slow_mem_en;
    logic [DATA_W-1:0] slow_mem_q;
    logic [DATA_W-1:0] slow_rd_data;
    logic              slow_rd_valid;
    logic              slow_busy;
    logic [7:0]        slow_op_count;

    always #5 clock = ~clock;

    mem_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DEB), .READ_LAT(READ_LAT)
    ) u_dut (
        .clock(clock), .resetn(resetn), .step_sw(step_sw), .wr_sw(wr_sw),
        .addr_sw(addr_sw), .data_sw(data_sw), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_en(mem_en), .mem_q(mem_q), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .op_count(op_count)
    );

    mem_access_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEBOUNCE_CYCLES(DEB), .READ_LAT(SLOW_LAT)
    ) u_dut_slow (
        .clock(clock), .resetn(resetn), .step_sw(slow_step_sw), .wr_sw(slow_wr_sw),
        .addr_sw(addr_sw), .data_sw(data_sw), .mem_addr(slow_mem_addr), .mem_data(slow_mem_data),
        .mem_wren(slow_mem_wren), .mem_en(slow_mem_en), .mem_q(slow_mem_q), .rd_data(slow_rd_data),
        .rd_valid(slow_rd_valid), .busy(slow_busy), .op_count(slow_op_count)
    );

    // behavioural RAM: q is only meaningful READ_LAT cycles after a read strobe
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] ram_q1;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) ram[i] = '0;
    end

    always @(posedge clock) begin
        if (mem_en && mem_wren) ram[mem_addr] <= mem_data;
        if (mem_en && !mem_wren) ram_q1 <= ram[mem_addr];
        else                     ram_q1 <= DATA_W'($urandom);
        mem_q <= ram_q1;
    end

    typedef struct {
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                abort;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    logic [7:0]        exp_ops = 8'd0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                done_cnt = 0;
    int                issue_cnt = 0;
    int                slow_en_cnt = 0;

    task automatic chk(input string name, input bit ok, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (slow_mem_en) slow_en_cnt++;
    end

    // monitor: every mem_en strobe must match the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resetn && mem_en) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_mem_en", 1'b0, {23'd0, mem_wren, mem_addr}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    issue_cnt++;
                    chk("access_fields",
                        (mem_wren == e.wr) && (mem_addr == e.addr) && (!e.wr || mem_data == e.data),
                        {15'd0, mem_wren, 3'd0, mem_addr, mem_data},
                        {15'd0, e.wr, 3'd0, e.addr, e.data});
                    if (!e.abort) begin
                        if (e.wr) begin
                            exp_ops = exp_ops + 8'd1;
                            @(negedge clock);
                            chk("write_done", !mem_en && !busy && !rd_valid && op_count == exp_ops,
                                {mem_en, busy, rd_valid, op_count}, {3'b000, exp_ops});
                        end else begin
                            for (int k = 0; k < READ_LAT; k++) begin
                                @(negedge clock);
                                chk("read_pending", !mem_en && busy && op_count == exp_ops,
                                    {mem_en, busy, op_count}, {2'b01, exp_ops});
                            end
                            exp_ops = exp_ops + 8'd1;
                            @(negedge clock);
                            chk("read_done",
                                rd_valid && !busy && rd_data == e.data && op_count == exp_ops && mem_addr == e.addr,
                                {rd_valid, busy, op_count, rd_data, 3'd0, mem_addr},
                                {2'b10, exp_ops, e.data, 3'd0, e.addr});
                        end
                        done_cnt++;
                    end
                end
            end
        end
    end

    task automatic push_exp(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit abort);
        exp_t e;
        e.wr = wr;
        e.addr = a;
        e.data = wr ? d : ref_mem[a];
        e.abort = abort;
        if (wr) ref_mem[a] = d;
        sb_q.push_back(e);
    endtask

    task automatic wait_done(input int start, input bit flip, input bit wr,
                             input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        for (int i = 0; i < 80 && done_cnt == start; i++) begin
            @(negedge clock);
            if (flip && i == 6) begin
                wr_sw   = ~wr;
                addr_sw = ~a;
                data_sw = ~d;
            end
        end
        if (done_cnt == start) chk("access_timeout", 1'b0, 32'(done_cnt), 32'(start + 1));
    endtask

    task automatic do_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit flip);
        int start;
        wr_sw = wr;
        addr_sw = a;
        data_sw = d;
        repeat (10) @(negedge clock);
        push_exp(wr, a, d, 1'b0);
        start = done_cnt;
        step_sw = 1'b1;
        wait_done(start, flip, wr, a, d);
        step_sw = 1'b0;
        repeat (10) @(negedge clock);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int n_wrap;
        int en_before;
        for (int i = 0; i < 2**ADDR_W; i++) ref_mem[i] = '0;

        // reset with every switch high
        resetn       = 1'b0;
        step_sw      = 1'b1;
        wr_sw        = 1'b1;
        addr_sw      = '1;
        data_sw      = '1;
        slow_step_sw = 1'b0;
        slow_wr_sw   = 1'b0;
        slow_mem_q   = 8'h5A;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("reset_outputs",
                mem_addr == 0 && mem_data == 0 && !mem_wren && !mem_en && rd_data == 0 &&
                !rd_valid && !busy && op_count == 0,
                {mem_addr, mem_data, mem_wren, mem_en, rd_valid, busy, op_count}, 32'd0);
        end
        push_exp(1'b1, 5'h1F, 8'hFF, 1'b0);
        start = done_cnt;
        resetn = 1'b1;
        wait_done(start, 1'b0, 1'b1, 5'h1F, 8'hFF);
        step_sw = 1'b0;
        repeat (12) @(negedge clock);

        // directed write then read back
        do_access(1'b1, 5'h1A, 8'hC3, 1'b0);
        do_access(1'b0, 5'h1A, 8'h00, 1'b0);

        // bouncing step switch: toggles every 2 cycles, then settles high
        wr_sw   = 1'b0;
        addr_sw = 5'h1F;
        repeat (10) @(negedge clock);
        push_exp(1'b0, 5'h1F, 8'h00, 1'b0);
        start = done_cnt;
        for (int t = 0; t < 10; t++) begin
            step_sw = ~step_sw;
            repeat (2) @(negedge clock);
        end
        step_sw = 1'b1;
        wait_done(start, 1'b0, 1'b0, 5'h1F, 8'h00);
        step_sw = 1'b0;
        repeat (10) @(negedge clock);
        chk("bounce_single_access", issue_cnt == 4 && op_count == 8'd4, {issue_cnt[23:0], op_count}, {24'd4, 8'd4});

        // second clean press lands while the slow instance is still waiting on its read
        slow_step_sw = 1'b1;
        repeat (6) @(negedge clock);
        slow_step_sw = 1'b0;
        repeat (6) @(negedge clock);
        slow_step_sw = 1'b1;
        repeat (8) @(negedge clock);
        chk("busy_during_second_press", slow_busy, {31'd0, slow_busy}, 32'd1);
        repeat (30) @(negedge clock);
        slow_step_sw = 1'b0;
        repeat (12) @(negedge clock);
        chk("press_during_busy_dropped",
            slow_en_cnt == 1 && slow_op_count == 8'd1 && slow_rd_valid && slow_rd_data == 8'h5A,
            {slow_en_cnt[14:0], slow_rd_valid, slow_op_count, slow_rd_data},
            {15'd1, 1'b1, 8'd1, 8'h5A});

        // randomized accesses until op_count wraps back to 0
        n_wrap = 256 - int'(exp_ops);
        for (int n = 0; n < n_wrap; n++) begin
            do_access(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                      1'($urandom_range(0, 1)));
        end
        chk("op_count_wrap", op_count == 8'd0 && exp_ops == 8'd0, {24'd0, op_count}, 32'd0);

        // reset during a read in flight
        wr_sw   = 1'b0;
        addr_sw = 5'h1A;
        repeat (10) @(negedge clock);
        push_exp(1'b0, 5'h1A, 8'h00, 1'b1);
        start = issue_cnt;
        step_sw = 1'b1;
        for (int i = 0; i < 40 && issue_cnt == start; i++) @(negedge clock);
        chk("abort_issue_seen", issue_cnt == start + 1, 32'(issue_cnt), 32'(start + 1));
        resetn = 1'b0;
        step_sw = 1'b0;
        repeat (3) @(negedge clock);
        exp_ops = 8'd0;
        chk("abort_reset_state", !rd_valid && !busy && !mem_en && op_count == 0,
            {rd_valid, busy, mem_en, op_count}, 32'd0);
        en_before = issue_cnt;
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        chk("abort_no_completion", !rd_valid && op_count == 0 && issue_cnt == en_before && sb_q.size() == 0,
            {rd_valid, op_count, issue_cnt[22:0]}, {1'b0, 8'd0, en_before[22:0]});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
